// File: rtl/acc_store_controller.sv
// acc_store_controller
//    Store-side companion of the accumulator load/store register. A store
//    request snapshots the accumulator value and the target address. The
//    block then runs a four-phase write handshake on the memory bus:
//    raise mem_we, wait for mem_ack high, drop mem_we, wait for mem_ack low.
//    Completion or timeout is reported back to the control unit.
//
//    Optional build macro: STORE_PARITY_EN adds mem_wpar, the XOR-reduction
//    parity of the captured data word.
//
// Ports
//    clock        system clock, rising edge
//    reset        synchronous, active-high reset
//    store_req    store request (only looked at while idle)
//    store_addr   target address, captured with store_req
//    acc_q        accumulator value, captured with store_req
//    mem_ack      memory acknowledge (four-phase)
//    mem_we       memory write strobe
//    mem_addr     registered write address
//    mem_wdata    registered write data
//    store_busy   high whenever a store is in flight
//    store_done   one-cycle pulse on successful completion
//    store_error  one-cycle pulse on timeout abort
//    mem_wpar     (STORE_PARITY_EN only) parity of mem_wdata
module acc_store_controller #(
   parameter int n       = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [n-1:0]      acc_q,
   input  logic              mem_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [n-1:0]      mem_wdata,
   output logic              store_busy,
   output logic              store_done,
   output logic              store_error
`ifdef STORE_PARITY_EN
   ,
   output logic              mem_wpar
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // The wait counter is eight bits regardless of n. It runs from 0, so
   // the abort fires on the TIMEOUT-th cycle spent in a waiting state.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] CNT_MAX  = 8'hFF;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [n-1:0]      mem_wdata_q, mem_wdata_d;
   logic              store_busy_q, store_busy_d;
   logic              store_done_q, store_done_d;
   logic              store_error_q, store_error_d;
`ifdef STORE_PARITY_EN
   logic              mem_wpar_q, mem_wpar_d;
`endif

   logic              cnt_expired;
   logic [7:0]        cnt_inc;

   assign cnt_expired = (cnt_q >= CNT_LAST);
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      store_done_d  = 1'b0;
      store_error_d = 1'b0;
`ifdef STORE_PARITY_EN
      mem_wpar_d    = mem_wpar_q;
`endif

      case (state_q)
         IDLE: begin
            if (store_req) begin
               state_d     = WRITE;
               cnt_d       = 8'd0;
               mem_addr_d  = store_addr;
               mem_wdata_d = acc_q;
`ifdef STORE_PARITY_EN
               mem_wpar_d  = ^acc_q;
`endif
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d = RELEASE;
               cnt_d   = 8'd0;
            end else if (cnt_expired) begin
               state_d       = IDLE;
               cnt_d         = 8'd0;
               store_error_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RELEASE: begin
            if (!mem_ack) begin
               state_d      = IDLE;
               cnt_d        = 8'd0;
               store_done_d = 1'b1;
            end else if (cnt_expired) begin
               state_d       = IDLE;
               cnt_d         = 8'd0;
               store_error_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // Strobe and busy are registered copies of the next state, so they
      // line up with the state they describe.
      mem_we_d     = (state_d == WRITE);
      store_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         store_busy_q  <= 1'b0;
         store_done_q  <= 1'b0;
         store_error_q <= 1'b0;
`ifdef STORE_PARITY_EN
         mem_wpar_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         store_busy_q  <= store_busy_d;
         store_done_q  <= store_done_d;
         store_error_q <= store_error_d;
`ifdef STORE_PARITY_EN
         mem_wpar_q    <= mem_wpar_d;
`endif
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign store_busy  = store_busy_q;
   assign store_done  = store_done_q;
   assign store_error = store_error_q;
`ifdef STORE_PARITY_EN
   assign mem_wpar    = mem_wpar_q;
`endif

endmodule

// File: tb/tb_acc_store_controller.sv
// Bench for acc_store_controller. The memory side is driven from an
// absolute timeline per store: ack rises `a` cycles into the write phase
// and falls `r` cycles into the release phase. Expected strobe/busy
// lengths and the outcome follow from that timeline with plain arithmetic.
module tb_acc_store_controller;
   localparam int N  = 8;
   localparam int AW = 8;
   localparam int TO = 15;

   logic          clock = 1'b0;
   logic          reset;
   logic          store_req;
   logic [AW-1:0] store_addr;
   logic [N-1:0]  acc_q;
   logic          mem_ack;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_wdata;
   logic          store_busy;
   logic          store_done;
   logic          store_error;
`ifdef STORE_PARITY_EN
   logic          mem_wpar;
`endif

   acc_store_controller #(.n(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .store_req   (store_req),
      .store_addr  (store_addr),
      .acc_q       (acc_q),
      .mem_ack     (mem_ack),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .store_busy  (store_busy),
      .store_done  (store_done),
      .store_error (store_error)
`ifdef STORE_PARITY_EN
      ,
      .mem_wpar    (mem_wpar)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // last captured values, as the memory should see them
   logic [AW-1:0] exp_addr = '0;
   logic [N-1:0]  exp_data = '0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [N-1:0]  data;
      int            a;        // write-phase cycles before ack rises
      int            r;        // release-phase cycles before ack falls
      int            we_len;   // expected cycles with mem_we high
      int            busy_len; // expected cycles with store_busy high
      bit            ok;       // 1: done pulse, 0: error pulse
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input bit we, input bit busy,
                              input bit done, input bit err);
      chk({tag, ".mem_we"},      32'(mem_we),      32'(we));
      chk({tag, ".store_busy"},  32'(store_busy),  32'(busy));
      chk({tag, ".store_done"},  32'(store_done),  32'(done));
      chk({tag, ".store_error"}, 32'(store_error), 32'(err));
      chk({tag, ".mem_addr"},    32'(mem_addr),    32'(exp_addr));
      chk({tag, ".mem_wdata"},   32'(mem_wdata),   32'(exp_data));
`ifdef STORE_PARITY_EN
      chk({tag, ".mem_wpar"},    32'(mem_wpar),    32'(^exp_data));
`endif
   endtask

   // Expected lengths/outcome from the handshake timing rules.
   function automatic void predict(input int a, input int r, output int we_len,
                                   output int busy_len, output bit ok);
      ok       = (a < TO) && (r < TO);
      we_len   = (a < TO) ? a + 1 : TO;
      busy_len = (a < TO) ? (a + 1) + ((r < TO) ? r + 1 : TO) : TO;
   endfunction

   // Entered at a falling edge with the DUT idle; returns at the falling edge
   // of the first idle cycle after the store (done/error already checked),
   // so a following call issues a back-to-back request.
   task automatic do_store(input string tag, input vec_t v);
      int rr;
      store_req  = 1'b1;
      store_addr = v.addr;
      acc_q      = v.data;
      mem_ack    = 1'b0;
      rr = (v.r < TO) ? v.r : TO;
      for (int c = 1; c <= v.busy_len + 1; c++) begin
         @(negedge clock);
         if (c == 1) begin
            exp_addr = v.addr;
            exp_data = v.data;
         end
         chk_outputs(tag, c <= v.we_len, c <= v.busy_len,
                     (c == v.busy_len + 1) && v.ok, (c == v.busy_len + 1) && !v.ok);
         // memory timeline
         mem_ack = (v.a < TO) && (c >= 1 + v.a) && (c <= 1 + v.a + rr);
         // requests while busy must be ignored
         if (c <= v.busy_len) begin
            store_req  = ($urandom_range(0, 1) == 1);
            store_addr = ~v.addr;
            acc_q      = 8'h5A;
         end else begin
            store_req = 1'b0;
         end
      end
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         store_req  = 1'b0;
         mem_ack    = 1'b0;
         acc_q      = N'($urandom);
         store_addr = AW'($urandom);
         @(negedge clock);
         chk_outputs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   vec_t vecs[9];
   vec_t v;

   initial begin
      // a, r, we_len, busy_len, ok   (TIMEOUT = 15)
      vecs[0] = '{addr: 8'h3C, data: 8'hA5, a: 2,  r: 1,  we_len: 3,  busy_len: 5,  ok: 1'b1};
      vecs[1] = '{addr: 8'h11, data: 8'h22, a: 99, r: 0,  we_len: 15, busy_len: 15, ok: 1'b0};
      vecs[2] = '{addr: 8'h40, data: 8'h07, a: 0,  r: 0,  we_len: 1,  busy_len: 2,  ok: 1'b1};
      vecs[3] = '{addr: 8'h41, data: 8'h03, a: 0,  r: 0,  we_len: 1,  busy_len: 2,  ok: 1'b1};
      vecs[4] = '{addr: 8'hFE, data: 8'hFF, a: 14, r: 0,  we_len: 15, busy_len: 16, ok: 1'b1};
      vecs[5] = '{addr: 8'h00, data: 8'h81, a: 15, r: 0,  we_len: 15, busy_len: 15, ok: 1'b0};
      vecs[6] = '{addr: 8'h7F, data: 8'h10, a: 0,  r: 14, we_len: 1,  busy_len: 16, ok: 1'b1};
      vecs[7] = '{addr: 8'h80, data: 8'h01, a: 0,  r: 15, we_len: 1,  busy_len: 16, ok: 1'b0};
      vecs[8] = '{addr: 8'h55, data: 8'hC3, a: 3,  r: 40, we_len: 4,  busy_len: 19, ok: 1'b0};

      reset = 1'b1; store_req = 1'b0; store_addr = '0; acc_q = '0; mem_ack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle_cycles("idle", 2);

      // table: vectors 2 and 3 are issued back to back (zero-wait ack)
      for (int i = 0; i < 9; i++) begin
         do_store($sformatf("vec%0d", i), vecs[i]);
         if (i != 2) idle_cycles($sformatf("post%0d", i), 1);
      end

      // reset mid-write: strobe low, data/addr cleared, no pulses
      store_req = 1'b1; store_addr = 8'h3C; acc_q = 8'hA5; mem_ack = 1'b0;
      @(negedge clock);
      exp_addr = 8'h3C; exp_data = 8'hA5;
      chk_outputs("rstmid.w", 1'b1, 1'b1, 1'b0, 1'b0);
      store_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      exp_addr = '0; exp_data = '0;
      chk_outputs("rstmid.r", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle_cycles("rstmid.i", 2);

      // reset wins over a simultaneous request
      reset = 1'b1; store_req = 1'b1; store_addr = 8'h99; acc_q = 8'h66;
      @(negedge clock);
      chk_outputs("rstprio", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; store_req = 1'b0;
      idle_cycles("rstprio.i", 1);

      // randomized stores with random gaps (including back to back)
      for (int t = 0; t < 40; t++) begin
         v.addr = AW'($urandom);
         v.data = N'($urandom);
         v.a    = $urandom_range(0, 17);
         v.r    = $urandom_range(0, 17);
         predict(v.a, v.r, v.we_len, v.busy_len, v.ok);
         do_store($sformatf("rnd%0d", t), v);
         idle_cycles($sformatf("rndgap%0d", t), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
